// File: rtl/cpu_core_if.sv
// Instruction-memory fetch handshake between cpu_core and the instruction ROM.
//   imem_req   core -> rom  fetch request, held until imem_ack
//   imem_addr  core -> rom  fetch address (program counter)
//   imem_ack   rom -> core  instruction valid, may be given in the same cycle as imem_req
//   imem_data  rom -> core  instruction word {op[3:0], f1, f2, f3}
// Modports: master (core side), slave (memory side).
interface cpu_core_if #(
   parameter int unsigned w    = 8,
   parameter int unsigned pc_w = 8
);
   localparam int unsigned IW = 4 + 3 * w;

   logic            imem_req;
   logic [pc_w-1:0] imem_addr;
   logic            imem_ack;
   logic [IW-1:0]   imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_data
   );
endinterface

// File: rtl/cpu_core.sv
// Multi-cycle processor core: FETCH -> DECODE -> EXEC per instruction, HALT on stop/fault.
// Ports:
//   clock      rising-edge system clock
//   reset_n    synchronous active-low reset
//   imem       cpu_core_if.master fetch handshake (req/addr out, ack/data in)
//   out_data   output port value, holds between OUT instructions
//   out_valid  one-cycle strobe for out_data
//   zero       ALU zero flag
//   carry      ALU carry / borrow flag
//   halted     core stopped
//   fault      core stopped on an illegal opcode
module cpu_core #(
   parameter int unsigned w     = 8,
   parameter int unsigned sel_w = 4,
   parameter int unsigned pc_w  = 8
) (
   input  logic          clock,
   input  logic          reset_n,
   cpu_core_if.master    imem,
   output logic [w-1:0]  out_data,
   output logic          out_valid,
   output logic          zero,
   output logic          carry,
   output logic          halted,
   output logic          fault
);

   localparam int unsigned IW      = 4 + 3 * w;
   localparam int unsigned NumRegs = 2 ** sel_w;

   localparam logic [3:0] OpNop  = 4'd0;
   localparam logic [3:0] OpLdi  = 4'd1;
   localparam logic [3:0] OpAdd  = 4'd2;
   localparam logic [3:0] OpSub  = 4'd3;
   localparam logic [3:0] OpAnd  = 4'd4;
   localparam logic [3:0] OpOr   = 4'd5;
   localparam logic [3:0] OpXor  = 4'd6;
   localparam logic [3:0] OpShl  = 4'd7;
   localparam logic [3:0] OpJmp  = 4'd8;
   localparam logic [3:0] OpJz   = 4'd9;
   localparam logic [3:0] OpOut  = 4'd10;
   localparam logic [3:0] OpHalt = 4'd15;

   typedef enum logic [1:0] {StFetch, StDecode, StExec, StHalt} state_e;

   state_e            state_q;
   logic [pc_w-1:0]   pc_q;
   logic              req_q;
   logic [IW-1:0]     ir_q;
   logic [w-1:0]      rx_q;
   logic [w-1:0]      ry_q;
   logic [sel_w-1:0]  dest_q;
   logic [w-1:0]      regs_q [NumRegs];
   logic [w-1:0]      out_data_q;
   logic              out_valid_q;
   logic              zero_q;
   logic              carry_q;
   logic              halted_q;
   logic              fault_q;

   // Instruction fields
   logic [3:0]        op;
   logic [w-1:0]      f1;
   logic [w-1:0]      f2;
   logic [w-1:0]      f3;
   logic [pc_w-1:0]   f1_pc;

   assign op    = ir_q[IW-1 -: 4];
   assign f1    = ir_q[3*w-1 -: w];
   assign f2    = ir_q[2*w-1 -: w];
   assign f3    = ir_q[w-1:0];
   assign f1_pc = pc_w'(f1);

   // f3 only selects a register; its upper bits carry no meaning
   logic unused_f3_hi;
   assign unused_f3_hi = ^f3[w-1:sel_w];

   // ALU
   logic [w:0]   sum;
   logic [w-1:0] res;
   logic         cout;
   logic         alu_op;

   always_comb begin
      sum  = '0;
      res  = '0;
      cout = 1'b0;
      case (op)
         OpAdd: begin
            sum  = {1'b0, rx_q} + {1'b0, ry_q};
            res  = sum[w-1:0];
            cout = sum[w];
         end
         OpSub: begin
            // Top bit of the extended difference is the borrow (rx < ry)
            sum  = {1'b0, rx_q} - {1'b0, ry_q};
            res  = sum[w-1:0];
            cout = sum[w];
         end
         OpAnd: res = rx_q & ry_q;
         OpOr:  res = rx_q | ry_q;
         OpXor: res = rx_q ^ ry_q;
         OpShl: begin
            res  = {rx_q[w-2:0], 1'b0};
            cout = rx_q[w-1];
         end
         default: ;
      endcase
   end

   assign alu_op = (op >= OpAdd) && (op <= OpShl);

   // Sequencer, datapath registers and registered outputs
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= StFetch;
         pc_q        <= '0;
         req_q       <= 1'b0;
         ir_q        <= '0;
         rx_q        <= '0;
         ry_q        <= '0;
         dest_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         halted_q    <= 1'b0;
         fault_q     <= 1'b0;
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         out_valid_q <= 1'b0;
         unique case (state_q)
            StFetch: begin
               // An ack only counts while the request is actually raised
               if (req_q && imem.imem_ack) begin
                  ir_q    <= imem.imem_data;
                  req_q   <= 1'b0;
                  state_q <= StDecode;
               end else begin
                  req_q <= 1'b1;
               end
            end
            StDecode: begin
               rx_q    <= regs_q[f2[sel_w-1:0]];
               ry_q    <= regs_q[f3[sel_w-1:0]];
               dest_q  <= f1[sel_w-1:0];
               state_q <= StExec;
            end
            StExec: begin
               state_q <= StFetch;
               req_q   <= 1'b1;
               pc_q    <= pc_q + pc_w'(1);
               if (alu_op) begin
                  if (dest_q != '0) begin
                     regs_q[dest_q] <= res;
                  end
                  zero_q  <= (res == '0);
                  carry_q <= cout;
               end else begin
                  case (op)
                     OpNop: ;
                     OpLdi: begin
                        if (dest_q != '0) begin
                           regs_q[dest_q] <= f2;
                        end
                     end
                     OpJmp: pc_q <= f1_pc;
                     OpJz: begin
                        if (rx_q == '0) begin
                           pc_q <= f1_pc;
                        end
                     end
                     OpOut: begin
                        out_data_q  <= rx_q;
                        out_valid_q <= 1'b1;
                     end
                     OpHalt: begin
                        halted_q <= 1'b1;
                        req_q    <= 1'b0;
                        state_q  <= StHalt;
                     end
                     default: begin
                        // Illegal opcode: pc stays on the faulting instruction
                        pc_q     <= pc_q;
                        halted_q <= 1'b1;
                        fault_q  <= 1'b1;
                        req_q    <= 1'b0;
                        state_q  <= StHalt;
                     end
                  endcase
               end
            end
            StHalt: ;
            default: state_q <= StHalt;
         endcase
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign out_data       = out_data_q;
   assign out_valid      = out_valid_q;
   assign zero           = zero_q;
   assign carry          = carry_q;
   assign halted         = halted_q;
   assign fault          = fault_q;

endmodule

// File: tb/tb_cpu_core.sv
module tb_cpu_core;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       zero;
   logic       carry;
   logic       halted;
   logic       fault;

   int total = 0;
   int bad   = 0;

   cpu_core_if #(.w(8), .pc_w(8)) bus ();

   cpu_core #(.w(8), .sel_w(4), .pc_w(8)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .imem      (bus),
      .out_data  (out_data),
      .out_valid (out_valid),
      .zero      (zero),
      .carry     (carry),
      .halted    (halted),
      .fault     (fault)
   );

   always #5 clock = ~clock;

   // Instruction ROM with a programmable number of wait states per fetch
   logic [27:0] rom [256];
   int delay = 0;
   int wait_cnt = 0;

   assign bus.imem_ack  = bus.imem_req && (wait_cnt >= delay);
   assign bus.imem_data = rom[bus.imem_addr];

   always @(posedge clock) begin
      if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   // Request/address must stay put while a fetch waits for its ack
   logic       pend = 1'b0;
   logic [7:0] paddr = '0;
   int         viol = 0;
   always @(posedge clock) begin
      pend  <= reset_n && bus.imem_req && !bus.imem_ack;
      paddr <= bus.imem_addr;
   end
   always @(negedge clock) begin
      if (reset_n && pend && (!bus.imem_req || bus.imem_addr != paddr)) viol <= viol + 1;
   end

   // Log of every out_valid strobe
   logic [7:0] out_log [64];
   int         out_cnt = 0;
   always @(negedge clock) begin
      if (out_valid && out_cnt < 64) begin
         out_log[out_cnt] <= out_data;
         out_cnt          <= out_cnt + 1;
      end
   end

   function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] c);
      return {op, a, b, c};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = '0;
   endtask

   task automatic run_cycles(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Counts edges until halted, bounded by budget
   task automatic run_halt(input int budget, output int n);
      n = 0;
      while (!halted && n < budget) begin
         @(posedge clock);
         #1;
         n++;
      end
   endtask

   // One reset cycle, reset-state checks, then release; returns just after the release edge
   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      check({tag, ".rst_req"},   bus.imem_req, 0);
      check({tag, ".rst_addr"},  bus.imem_addr, 0);
      check({tag, ".rst_flags"}, {out_data, out_valid, zero, carry, halted, fault}, 0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check({tag, ".rel_req"}, bus.imem_req, 1);
   endtask

   task automatic load_prog1();
      clear_rom();
      rom[0] = ins(4'd1, 8'd1, 8'd5, 8'd0);   // LDI r1,5
      rom[1] = ins(4'd1, 8'd2, 8'd7, 8'd0);   // LDI r2,7
      rom[2] = ins(4'd2, 8'd3, 8'd1, 8'd2);   // ADD r3,r1,r2
      rom[3] = ins(4'd10, 8'd0, 8'd3, 8'd0);  // OUT r3
      rom[4] = ins(4'd15, 8'd0, 8'd0, 8'd0);  // HALT
   endtask

   int n;
   int base;
   int v0;

   initial begin
      // 1: basic program, zero wait
      load_prog1();
      delay = 0;
      do_reset("t1");
      base = out_cnt;
      v0 = viol;
      run_halt(200, n);
      check("t1.cycles", n, 15);
      check("t1.nout", out_cnt - base, 1);
      check("t1.out0", out_log[base], 8'h0C);
      check("t1.flags", {zero, carry, halted, fault}, 4'b0010);
      check("t1.req_halt", bus.imem_req, 0);
      check("t1.hold", out_data, 8'h0C);

      // 2: carry, zero and borrow
      clear_rom();
      rom[0] = ins(4'd1, 8'd1, 8'hFF, 8'd0);  // LDI r1,FF
      rom[1] = ins(4'd1, 8'd2, 8'h01, 8'd0);  // LDI r2,01
      rom[2] = ins(4'd2, 8'd3, 8'd1, 8'd2);   // ADD r3,r1,r2
      rom[3] = ins(4'd10, 8'd0, 8'd3, 8'd0);  // OUT r3
      rom[4] = ins(4'd3, 8'd4, 8'd2, 8'd1);   // SUB r4,r2,r1
      rom[5] = ins(4'd10, 8'd0, 8'd4, 8'd0);  // OUT r4
      rom[6] = ins(4'd15, 8'd0, 8'd0, 8'd0);  // HALT
      do_reset("t2");
      base = out_cnt;
      run_cycles(9);
      check("t2.add_zc", {zero, carry}, 2'b11);
      run_halt(200, n);
      check("t2.cycles", n, 12);
      check("t2.nout", out_cnt - base, 2);
      check("t2.out0", out_log[base], 8'h00);
      check("t2.out1", out_log[base + 1], 8'h02);
      check("t2.sub_zc", {zero, carry}, 2'b01);

      // 3: countdown loop straddling the pc wrap
      clear_rom();
      rom[8'h00] = ins(4'd9, 8'h10, 8'd6, 8'd0);  // JZ r6,10
      rom[8'h01] = ins(4'd10, 8'd0, 8'd1, 8'd0);  // OUT r1
      rom[8'h02] = ins(4'd9, 8'h30, 8'd1, 8'd0);  // JZ r1,30
      rom[8'h03] = ins(4'd8, 8'hFF, 8'd0, 8'd0);  // JMP FF
      rom[8'h10] = ins(4'd1, 8'd1, 8'd3, 8'd0);   // LDI r1,3
      rom[8'h11] = ins(4'd1, 8'd2, 8'd1, 8'd0);   // LDI r2,1
      rom[8'h12] = ins(4'd1, 8'd6, 8'd1, 8'd0);   // LDI r6,1
      rom[8'h13] = ins(4'd8, 8'hFF, 8'd0, 8'd0);  // JMP FF
      rom[8'hFF] = ins(4'd3, 8'd1, 8'd1, 8'd2);   // SUB r1,r1,r2
      rom[8'h30] = ins(4'd15, 8'd0, 8'd0, 8'd0);  // HALT
      do_reset("t3");
      base = out_cnt;
      run_halt(500, n);
      check("t3.cycles", n, 60);
      check("t3.nout", out_cnt - base, 3);
      check("t3.outs", {out_log[base], out_log[base + 1], out_log[base + 2]}, 24'h020100);
      check("t3.flags", {zero, carry, halted, fault}, 4'b1010);

      // 4: wait states
      load_prog1();
      delay = 1;
      do_reset("t4a");
      base = out_cnt;
      run_halt(300, n);
      check("t4a.cycles", n, 20);
      check("t4a.out0", {out_cnt - base, 24'(out_log[base])}, {32'd1, 24'h0C});
      delay = 4;
      do_reset("t4b");
      base = out_cnt;
      run_halt(300, n);
      check("t4b.cycles", n, 35);
      check("t4b.out0", {out_cnt - base, 24'(out_log[base])}, {32'd1, 24'h0C});
      check("t4b.flags", {zero, carry, halted, fault}, 4'b0010);
      check("t4.stable", viol - v0, 0);
      delay = 0;

      // 5: illegal opcode at 0x03, r0 write discarded
      clear_rom();
      rom[0] = ins(4'd1, 8'd1, 8'h11, 8'd0);  // LDI r1,11
      rom[1] = ins(4'd2, 8'd0, 8'd1, 8'd1);   // ADD r0,r1,r1
      rom[2] = ins(4'd10, 8'd0, 8'd0, 8'd0);  // OUT r0
      rom[3] = ins(4'd12, 8'd0, 8'd0, 8'd0);  // illegal
      do_reset("t5");
      base = out_cnt;
      run_halt(200, n);
      check("t5.cycles", n, 12);
      check("t5.r0", {out_cnt - base, 24'(out_log[base])}, {32'd1, 24'h00});
      check("t5.status", {halted, fault, bus.imem_req}, 3'b110);
      check("t5.pc", bus.imem_addr, 8'h03);
      run_cycles(4);
      check("t5.hold", {halted, fault, bus.imem_req, bus.imem_addr}, {3'b110, 8'h03});

      // 6: reset during a fetch whose ack arrives in the reset cycle
      load_prog1();
      do_reset("t6a");
      run_cycles(6);
      check("t6.mid_req", {bus.imem_req, bus.imem_addr}, {1'b1, 8'h02});
      clear_rom();
      rom[0] = ins(4'd10, 8'd0, 8'd1, 8'd0);  // OUT r1
      rom[1] = ins(4'd10, 8'd0, 8'd2, 8'd0);  // OUT r2
      rom[2] = ins(4'd15, 8'd0, 8'd0, 8'd0);  // HALT
      do_reset("t6b");
      base = out_cnt;
      run_halt(200, n);
      check("t6.cycles", n, 9);
      check("t6.nout", out_cnt - base, 2);
      check("t6.regs0", {out_log[base], out_log[base + 1]}, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
